subbr_seq: RTL



---
 rtl/subbr_seq_pkg.sv | 14 +
 rtl/subbr_seq_if.sv | 26 ++
 rtl/subbr_seq_sub4.sv | 19 +
 rtl/subbr_seq.sv | 123 ++++++++++++
 4 files changed

// File: rtl/subbr_seq_pkg.sv
// subbr_seq shared definitions.
// State encodings and default datapath sizes.
package subbr_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subbr_seq_if.sv
// subbr_seq request/result bundle.
// Start/done handshake plus operands and result.
interface subbr_seq_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, q, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, q, bout
  );

endinterface

// File: rtl/subbr_seq_sub4.sv
// One combinational subtractor slice.
// {bo,d} = x - y - bi over SLICE bits.
module subbr_seq_sub4 #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             bi,
  output logic [SLICE-1:0] d,
  output logic             bo
);

  // Extended difference: the sign bit is the borrow.
  always_comb begin
    {bo, d} = {1'b0, x} - {1'b0, y}
            - {{SLICE{1'b0}}, bi};
  end

endmodule

// File: rtl/subbr_seq.sv
// Multi-cycle unsigned subtractor with borrow.
// One slice per clock, LSB first, borrow in a register.
module subbr_seq
  import subbr_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic       clk,
  input  logic       rst_n,
  subbr_seq_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ?
                      $clog2(NSLICE) : 1;

  if (WIDTH % SLICE != 0) begin : g_bad_cfg
    $error("subbr_seq: WIDTH not a multiple of SLICE");
  end

  state_t st;
  state_t nxt;

  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_r;
  logic             bout_r;

  logic [SLICE-1:0] d;
  logic             bo;

  assign last = (cnt == CW'(NSLICE - 1));

  subbr_seq_sub4 #(
    .SLICE (SLICE)
  ) u_slice (
    .x  (a_r[SLICE-1:0]),
    .y  (b_r[SLICE-1:0]),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= nxt;
  end

  // Next state plus load/step strobes.
  always_comb begin
    nxt  = st;
    load = 1'b0;
    step = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (bus.start) begin
          nxt  = ST_RUN;
          load = 1'b1;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last) nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.start) begin
          nxt  = ST_RUN;
          load = 1'b1;
        end else begin
          nxt = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Operands shift right so the live slice
  // is always in the low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      brw <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      a_r <= bus.a;
      b_r <= bus.b;
      brw <= bus.bin;
      cnt <= '0;
    end else if (step) begin
      a_r <= a_r >> SLICE;
      b_r <= b_r >> SLICE;
      brw <= bo;
      cnt <= cnt + CW'(1);
    end
  end

  // Result slices land in place; bout on the
  // final slice. Both hold until the next run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= '0;
      bout_r <= 1'b0;
    end else if (step) begin
      q_r[int'(cnt)*SLICE +: SLICE] <= d;
      if (last) bout_r <= bo;
    end
  end

  assign bus.busy = (st == ST_RUN);
  assign bus.done = (st == ST_DONE);
  assign bus.q    = q_r;
  assign bus.bout = bout_r;

endmodule
